// File: rtl/piezo_pkg.sv
// rtl/piezo_pkg.sv - shared state encoding, defaults and priority encoder for the piezo arbiter
package piezo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } piezo_state_e;

  localparam int GAP_US_DEF      = 20000;
  localparam int MIN_HOLD_US_DEF = 100000;
  localparam int CNT_W_DEF       = 20;

  // Lowest set index wins; returns 0 for an empty vector.
  function automatic logic [2:0] prio_enc(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/piezo_us_timer.sv
// rtl/piezo_us_timer.sv - clearable microsecond up-counter saturating at LIMIT
module piezo_us_timer #(
  parameter int CNT_W = 20,
  parameter int LIMIT = 1
) (
  input  logic CLK_1MHZ,
  input  logic RESETN,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count_q, count_d;

  // Clear wins over count; counting stops at LIM so the value never wraps.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LIM)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge CLK_1MHZ or negedge RESETN) begin
    if (!RESETN) count_q <= '0;
    else         count_q <= count_d;
  end

  assign done_o = (count_q == LIM);

endmodule

// File: rtl/piezo_arbiter.sv
// rtl/piezo_arbiter.sv - fixed-priority piezo owner arbiter with enforced silence gap
// Optional preemption of lower-priority owners: define PIEZO_ARB_PREEMPT_EN.
module piezo_arbiter
  import piezo_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int GAP_US      = GAP_US_DEF,
  parameter int MIN_HOLD_US = MIN_HOLD_US_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             RESETN,
  input  logic             CLK_1MHZ,
  input  logic             ENABLE,
  input  logic [N_REQ-1:0] REQ,
  input  logic [N_REQ-1:0] TONE_IN,
  output logic [N_REQ-1:0] GRANT,
  output logic [2:0]       GRANT_ID,
  output logic             BUSY,
  output logic             PIEZO
);

  piezo_state_e     state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [2:0]       owner_q, owner_d;
  logic             busy_q, busy_d;
  logic             piezo_q, piezo_d;
  logic [N_REQ-1:0] elig;
  logic [7:0]       elig_ext;
  logic             owner_req;
  logic             hold_done, gap_done;

`ifdef PIEZO_ARB_PREEMPT_EN
  logic [N_REQ-1:0] revoked_q, revoked_d;
  logic [N_REQ-1:0] higher;

  // A revoked source stays invisible until it drops its request once.
  assign elig = REQ & ~revoked_q;

  // Eligible requests that outrank the current owner.
  always_comb begin
    higher = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (3'(i) < owner_q) higher[i] = elig[i];
    end
  end
`else
  logic unused_hold_done;

  assign elig             = REQ;
  assign unused_hold_done = hold_done;
`endif

  // Widen eligible requests for the encoder and pick out the owner's own request line.
  always_comb begin
    elig_ext            = '0;
    elig_ext[N_REQ-1:0] = elig;
    owner_req           = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (3'(i) == owner_q) owner_req = REQ[i];
    end
  end

  // Next state and registered outputs; grant/tone follow the owner chosen for the next cycle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    busy_d  = 1'b0;
    grant_d = '0;
    piezo_d = 1'b0;
`ifdef PIEZO_ARB_PREEMPT_EN
    revoked_d = revoked_q & REQ;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (ENABLE && (|elig)) begin
          state_d = ST_OWN;
          owner_d = prio_enc(elig_ext);
          busy_d  = 1'b1;
        end
      end
      ST_OWN: begin
        busy_d = 1'b1;
        if (!ENABLE || !owner_req) begin
          state_d = ST_GAP;
          busy_d  = 1'b0;
        end
`ifdef PIEZO_ARB_PREEMPT_EN
        else if ((|higher) && hold_done) begin
          state_d = ST_GAP;
          busy_d  = 1'b0;
          for (int i = 0; i < N_REQ; i++) begin
            if (3'(i) == owner_q) revoked_d[i] = 1'b1;
          end
        end
`endif
      end
      ST_GAP: begin
        if (gap_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (busy_d) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (3'(i) == owner_d) begin
          grant_d[i] = 1'b1;
          piezo_d    = TONE_IN[i];
        end
      end
    end
  end

  // State and output registers; reset silences the pin without waiting for a clock.
  always_ff @(posedge CLK_1MHZ or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= 3'd0;
      busy_q  <= 1'b0;
      piezo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      piezo_q <= piezo_d;
    end
  end

`ifdef PIEZO_ARB_PREEMPT_EN
  // Per-source revoked flags.
  always_ff @(posedge CLK_1MHZ or negedge RESETN) begin
    if (!RESETN) revoked_q <= '0;
    else         revoked_q <= revoked_d;
  end
`endif

  // Timers are held clear outside their state, so each entry edge counts as cycle 1.
  piezo_us_timer #(.CNT_W(CNT_W), .LIMIT(MIN_HOLD_US)) u_hold_timer (
    .CLK_1MHZ (CLK_1MHZ),
    .RESETN   (RESETN),
    .clr_i    (state_d != ST_OWN),
    .en_i     (state_d == ST_OWN),
    .done_o   (hold_done)
  );

  piezo_us_timer #(.CNT_W(CNT_W), .LIMIT(GAP_US)) u_gap_timer (
    .CLK_1MHZ (CLK_1MHZ),
    .RESETN   (RESETN),
    .clr_i    (state_d != ST_GAP),
    .en_i     (state_d == ST_GAP),
    .done_o   (gap_done)
  );

  assign GRANT    = grant_q;
  assign GRANT_ID = owner_q;
  assign BUSY     = busy_q;
  assign PIEZO    = piezo_q;

endmodule
